apb_acc_shell: RTL and testbench

- Parametrised APB slave shell for the streaming matrix-multiply accelerator core (next generation of the fixed 64-in/160-out MMU wrapper).
- Holds a CPU-writable input buffer and a CPU-readable result buffer.
- Streams input elements to the core over a valid/ready interface, captures result elements from the core, and reports BUSY/DONE/ERR status with an optional interrupt.
- Sits on the peripheral APB bus; base-address decode is external (PSEL), and the block decodes PADDR[11:0].

---
 rtl/apb_acc_shell_if.sv | 45 ++++
 rtl/apb_acc_shell.sv | 182 ++++++++++++++++++
 tb/tb_apb_acc_shell.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_acc_shell_if.sv
// rtl/apb_acc_shell_if.sv - APB register port and core stream signals of the accelerator shell
interface apb_acc_shell_if #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 9
);
  logic [31:0]      PADDR;
  logic [31:0]      PWDATA;
  logic             PWRITE;
  logic             PSEL;
  logic             PENABLE;
  logic [31:0]      PRDATA;
  logic             PREADY;
  logic             PSLVERR;
  logic             s_valid_o;
  logic [IN_W-1:0]  s_data_o;
  logic             s_last_o;
  logic             s_ready_i;
  logic             m_valid_i;
  logic [OUT_W-1:0] m_data_i;
  logic             m_last_i;
  logic             m_ready_o;
  logic             irq_o;

  // CPU plus core side, as seen from outside the shell
  modport master (
    output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
    input  PRDATA, PREADY, PSLVERR,
    input  s_valid_o, s_data_o, s_last_o,
    output s_ready_i,
    output m_valid_i, m_data_i, m_last_i,
    input  m_ready_o,
    input  irq_o
  );

  // the shell itself
  modport slave (
    input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
    output PRDATA, PREADY, PSLVERR,
    output s_valid_o, s_data_o, s_last_o,
    input  s_ready_i,
    input  m_valid_i, m_data_i, m_last_i,
    output m_ready_o,
    output irq_o
  );
endinterface

// File: rtl/apb_acc_shell.sv
// rtl/apb_acc_shell.sv - APB slave shell buffering input/result data for a streaming accelerator core
module apb_acc_shell #(
  parameter int IN_DEPTH  = 64,
  parameter int OUT_DEPTH = 160,
  parameter int IN_W      = 8,
  parameter int OUT_W     = 9
) (
  input logic              HCLK,
  input logic              HRESETn,
  apb_acc_shell_if.slave   bus
);
  localparam int CW  = 10;
  localparam int IAW = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
  localparam int OAW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, SEND, COLLECT} state_t;

  state_t           state;
  logic [31:0]      inbuf  [IN_DEPTH];
  logic [OUT_W-1:0] outbuf [OUT_DEPTH];
  logic [CW-1:0]    len_q, out_cnt, idx;
  logic             irq_en, done, err;
  logic             s_valid_q, m_ready_q, irq_q;

  logic [11:0]   off, in_off;
  logic [CW-1:0] in_word, out_word;
  logic access, busy, aligned;
  logic is_ctrl, is_status, is_len, is_ocnt, is_in, is_out, mapped;
  logic slverr, wr_en, soft_rst, start_go, s_fire, m_fire, last_idx, cap;
  logic [31:0] rdata;
  logic unused_bits;

  assign off      = bus.PADDR[11:0];
  assign in_off   = off - 12'h100;
  assign in_word  = in_off[11:2];
  assign out_word = {1'b0, off[10:2]};
  assign aligned  = (off[1:0] == 2'b00);
  assign access   = bus.PSEL & bus.PENABLE;
  assign busy     = (state != IDLE);

  assign is_ctrl   = (off == 12'h000);
  assign is_status = (off == 12'h004);
  assign is_len    = (off == 12'h008);
  assign is_ocnt   = (off == 12'h00C);
  assign is_in     = aligned && (off >= 12'h100) && (off < 12'h800) && (in_word < CW'(IN_DEPTH));
  assign is_out    = aligned && off[11] && (out_word < CW'(OUT_DEPTH));
  assign mapped    = is_ctrl | is_status | is_len | is_ocnt | is_in | is_out;

  // Reject accesses that must not take effect; SOFT_RST overrides a START written alongside it
  always_comb begin
    slverr = 1'b0;
    if (!mapped)
      slverr = 1'b1;
    else if (bus.PWRITE && (is_ocnt || is_out))
      slverr = 1'b1;
    else if (bus.PWRITE && busy && (is_in || is_len))
      slverr = 1'b1;
    else if (bus.PWRITE && is_ctrl && bus.PWDATA[0] && !bus.PWDATA[2] &&
             (busy || len_q == '0 || len_q > CW'(IN_DEPTH)))
      slverr = 1'b1;
  end

  assign wr_en    = access & bus.PWRITE & ~slverr;
  assign soft_rst = wr_en & is_ctrl & bus.PWDATA[2];
  assign start_go = wr_en & is_ctrl & bus.PWDATA[0] & ~bus.PWDATA[2];
  assign s_fire   = s_valid_q & bus.s_ready_i;
  assign m_fire   = bus.m_valid_i & m_ready_q;
  assign last_idx = (idx == len_q - CW'(1));
  assign cap      = m_fire & ~soft_rst & (out_cnt < CW'(OUT_DEPTH));

  // Read data is only driven during a successful read access phase
  always_comb begin
    rdata = '0;
    if (access && !bus.PWRITE && !slverr) begin
      if (is_ctrl)        rdata = {30'd0, irq_en, 1'b0};
      else if (is_status) rdata = {29'd0, err, done, busy};
      else if (is_len)    rdata = {{(32-CW){1'b0}}, len_q};
      else if (is_ocnt)   rdata = {{(32-CW){1'b0}}, out_cnt};
      else if (is_in)     rdata = inbuf[in_word[IAW-1:0]];
      else if (is_out)    rdata = 32'(outbuf[out_word[OAW-1:0]]);
    end
  end

  assign bus.PRDATA    = rdata;
  assign bus.PSLVERR   = access & slverr;
  assign bus.PREADY    = 1'b1;
  assign bus.s_valid_o = s_valid_q;
  assign bus.s_data_o  = inbuf[idx[IAW-1:0]][IN_W-1:0];
  assign bus.s_last_o  = s_valid_q & last_idx;
  assign bus.m_ready_o = m_ready_q;
  assign bus.irq_o     = irq_q;
  assign unused_bits   = ^{bus.PADDR[31:12], in_off[1:0]};

  // CPU writes into the input buffer
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int i = 0; i < IN_DEPTH; i++) inbuf[i] <= '0;
    end else if (wr_en && is_in) begin
      inbuf[in_word[IAW-1:0]] <= bus.PWDATA;
    end
  end

  // Results from the core land at the current capture count
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int j = 0; j < OUT_DEPTH; j++) outbuf[j] <= '0;
    end else if (cap) begin
      outbuf[out_cnt[OAW-1:0]] <= bus.m_data_i;
    end
  end

  // Control registers, sequencing FSM, status flags and registered interrupt
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state     <= IDLE;
      len_q     <= '0;
      out_cnt   <= '0;
      idx       <= '0;
      irq_en    <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      s_valid_q <= 1'b0;
      m_ready_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      if (wr_en && is_ctrl) irq_en <= bus.PWDATA[1];
      if (wr_en && is_len)  len_q  <= bus.PWDATA[CW-1:0];
      if (soft_rst) begin
        state     <= IDLE;
        s_valid_q <= 1'b0;
        m_ready_q <= 1'b0;
        done      <= 1'b0;
        err       <= 1'b0;
        out_cnt   <= '0;
        idx       <= '0;
      end else begin
        // W1C first so that a hardware set later in this block wins
        if (wr_en && is_status) begin
          done <= done & ~bus.PWDATA[1];
          err  <= err & ~bus.PWDATA[2];
        end
        case (state)
          IDLE: begin
            if (start_go) begin
              state     <= SEND;
              s_valid_q <= 1'b1;
              m_ready_q <= 1'b1;
              done      <= 1'b0;
              err       <= 1'b0;
              out_cnt   <= '0;
              idx       <= '0;
            end
          end
          SEND: begin
            if (s_fire) begin
              idx <= idx + CW'(1);
              if (last_idx) begin
                state     <= COLLECT;
                s_valid_q <= 1'b0;
              end
            end
          end
          default: ;
        endcase
        if (m_fire) begin
          if (out_cnt < CW'(OUT_DEPTH)) out_cnt <= out_cnt + CW'(1);
          else                          err     <= 1'b1;
          if (bus.m_last_i) begin
            if (state == COLLECT) begin
              state     <= IDLE;
              done      <= 1'b1;
              m_ready_q <= 1'b0;
            end else begin
              err <= 1'b1;
            end
          end
        end
      end
      irq_q <= irq_en & (done | err);
    end
  end
endmodule

// File: tb/tb_apb_acc_shell.sv
// tb/tb_apb_acc_shell.sv - scoreboard bench for the APB accelerator shell
module tb_apb_acc_shell;
  localparam int IN_DEPTH = 8, OUT_DEPTH = 4, IN_W = 8, OUT_W = 9;
  localparam logic [31:0] A_CTRL = 32'h000, A_STAT = 32'h004, A_LEN = 32'h008, A_OCNT = 32'h00C;
  localparam logic [31:0] A_IN = 32'h100, A_OUT = 32'h800;

  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  apb_acc_shell_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();
  apb_acc_shell #(.IN_DEPTH(IN_DEPTH), .OUT_DEPTH(OUT_DEPTH), .IN_W(IN_W), .OUT_W(OUT_W))
    dut (.HCLK(HCLK), .HRESETn(HRESETn), .bus(bus));

  always #5 HCLK = ~HCLK;

  int checks = 0;
  int errors = 0;
  logic [IN_W:0]    exp_s[$];
  logic [OUT_W-1:0] exp_r[$];
  logic [31:0]      mem [IN_DEPTH];
  logic             irq_en_m = 1'b0;

  task automatic apb_write(input logic [31:0] a, input logic [31:0] d, output logic e);
    bus.PADDR = a; bus.PWDATA = d; bus.PWRITE = 1'b1; bus.PSEL = 1'b1; bus.PENABLE = 1'b0;
    @(posedge HCLK); #1 bus.PENABLE = 1'b1;
    #3 e = bus.PSLVERR;
    @(posedge HCLK); #1 bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] a, output logic [31:0] d, output logic e);
    bus.PADDR = a; bus.PWRITE = 1'b0; bus.PSEL = 1'b1; bus.PENABLE = 1'b0;
    @(posedge HCLK); #1 bus.PENABLE = 1'b1;
    #3 d = bus.PRDATA; e = bus.PSLVERR;
    @(posedge HCLK); #1 bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
  endtask

  task automatic load(input int n, input logic [7:0] base);
    logic e;
    for (int i = 0; i < n; i++) begin
      mem[i] = {24'($urandom), base + 8'((i + 1) * 17)};
      apb_write(A_IN + 32'(4 * i), mem[i], e);
    end
  endtask

  task automatic start_run(input int n);
    logic e;
    apb_write(A_LEN, 32'(n), e);
    apb_write(A_CTRL, {30'd0, irq_en_m, 1'b1}, e);
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL start_accept: pslverr=%b want 0", e); end
    for (int i = 0; i < n; i++) exp_s.push_back({(i == n - 1), mem[i][IN_W-1:0]});
  endtask

  task automatic run_send(input int n, input bit toggle, output int cyc);
    int got = 0;
    bit held = 0;
    logic [IN_W:0] prev = '0;
    logic [IN_W:0] obs, want;
    cyc = 0;
    while (got < n && cyc < 200) begin
      bus.s_ready_i = toggle ? cyc[0] : 1'b1;
      #3;
      obs = {bus.s_last_o, bus.s_data_o};
      if (bus.s_valid_o) begin
        if (held) begin
          checks++; if (obs !== prev) begin errors++; $display("FAIL send_hold: got %h want %h", obs, prev); end
        end
        if (bus.s_ready_i) begin
          want = exp_s.pop_front();
          checks++; if (obs !== want) begin errors++; $display("FAIL send_data: got %h want %h", obs, want); end
          got++; held = 0;
        end else begin
          held = 1; prev = obs;
        end
      end
      @(posedge HCLK); #1 cyc++;
    end
    bus.s_ready_i = 1'b0;
    checks++; if (got != n) begin errors++; $display("FAIL send_timeout: got %0d transfers want %0d", got, n); end
  endtask

  task automatic core_ret(input logic [OUT_W-1:0] d, input logic l, input bit store);
    bus.m_valid_i = 1'b1; bus.m_data_i = d; bus.m_last_i = l;
    if (store) exp_r.push_back(d);
    @(posedge HCLK); #1 bus.m_valid_i = 1'b0; bus.m_last_i = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] d; logic e;
    bus.PADDR = '0; bus.PWDATA = '0; bus.PWRITE = 1'b0; bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
    bus.s_ready_i = 1'b0; bus.m_valid_i = 1'b0; bus.m_data_i = '0; bus.m_last_i = 1'b0;
    repeat (3) @(posedge HCLK); #1;
    checks++; if ({bus.PRDATA, bus.PSLVERR, bus.PREADY} !== {32'd0, 1'b0, 1'b1}) begin errors++; $display("FAIL reset_apb: prdata=%h slverr=%b ready=%b", bus.PRDATA, bus.PSLVERR, bus.PREADY); end
    checks++; if ({bus.s_valid_o, bus.s_last_o, bus.m_ready_o, bus.irq_o} !== 4'b0000) begin errors++; $display("FAIL reset_stream: got %b%b%b%b want 0000", bus.s_valid_o, bus.s_last_o, bus.m_ready_o, bus.irq_o); end
    HRESETn = 1'b1;
    @(posedge HCLK); #1;
    apb_read(A_STAT, d, e);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_status: got %h want 0", d); end
    apb_read(A_LEN, d, e);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_len: got %h want 0", d); end
    apb_read(A_IN, d, e);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_inbuf: got %h want 0", d); end
  endtask

  task automatic test_nominal;
    logic [31:0] d; logic e; int cyc;
    load(4, 8'h00);
    start_run(4);
    run_send(4, 1'b0, cyc);
    checks++; if (cyc != 4) begin errors++; $display("FAIL nominal_consecutive: took %0d cycles want 4", cyc); end
    core_ret(9'h1FF, 1'b0, 1'b1);
    core_ret(9'h005, 1'b1, 1'b1);
    apb_read(A_OCNT, d, e);
    checks++; if (d !== 32'd2) begin errors++; $display("FAIL nominal_outcnt: got %0d want 2", d); end
    apb_read(A_STAT, d, e);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL nominal_status: got %h want 2", d); end
    for (int j = 0; j < 2; j++) begin
      apb_read(A_OUT + 32'(4 * j), d, e);
      checks++; if (d !== 32'(exp_r[0])) begin errors++; $display("FAIL nominal_outbuf%0d: got %h want %h", j, d, exp_r[0]); end
      void'(exp_r.pop_front());
    end
    checks++; if (bus.irq_o !== 1'b0) begin errors++; $display("FAIL nominal_irq: got %b want 0", bus.irq_o); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] d; logic e; int cyc;
    load(3, 8'h40);
    start_run(3);
    run_send(3, 1'b1, cyc);
    checks++; if ({bus.s_valid_o, bus.m_ready_o} !== 2'b01) begin errors++; $display("FAIL bp_collect: valid/ready=%b%b want 01", bus.s_valid_o, bus.m_ready_o); end
    fork
      apb_read(A_STAT, d, e);
      begin @(posedge HCLK); #1 core_ret(9'h0AB, 1'b1, 1'b1); end
    join
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL bp_status_preedge: got %h want 1", d); end
    apb_read(A_STAT, d, e);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL bp_status_done: got %h want 2", d); end
    apb_read(A_OUT, d, e);
    checks++; if (d !== 32'(exp_r[0])) begin errors++; $display("FAIL bp_outbuf: got %h want %h", d, exp_r[0]); end
    void'(exp_r.pop_front());
  endtask

  task automatic test_errors;
    logic [31:0] d; logic e;
    apb_write(A_STAT, 32'h6, e);
    apb_write(A_LEN, 32'd0, e);
    apb_write(A_CTRL, 32'h1, e);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL err_len0: pslverr=%b want 1", e); end
    apb_read(A_STAT, d, e);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL err_len0_busy: status=%h want 0", d); end
    apb_write(A_LEN, 32'd9, e);
    apb_write(A_CTRL, 32'h1, e);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL err_len_big: pslverr=%b want 1", e); end
    apb_read(32'h010, d, e);
    checks++; if ({e, d} !== {1'b1, 32'd0}) begin errors++; $display("FAIL err_unmapped: pslverr=%b prdata=%h want 1/0", e, d); end
    apb_write(A_OCNT, 32'h5, e);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL err_wr_outcnt: pslverr=%b want 1", e); end
    apb_write(A_OUT, 32'h5, e);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL err_wr_outbuf: pslverr=%b want 1", e); end
    load(2, 8'h80);
    start_run(2);
    apb_write(A_IN, 32'hDEADBEEF, e);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL err_wr_busy: pslverr=%b want 1", e); end
    apb_read(A_IN, d, e);
    checks++; if (d !== mem[0]) begin errors++; $display("FAIL err_inbuf_kept: got %h want %h", d, mem[0]); end
    apb_write(A_CTRL, 32'h1, e);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL err_start_busy: pslverr=%b want 1", e); end
    apb_write(A_CTRL, 32'h4, e);
    exp_s.delete();
    checks++; if (bus.s_valid_o !== 1'b0) begin errors++; $display("FAIL err_abort: s_valid=%b want 0", bus.s_valid_o); end
  endtask

  task automatic test_overflow;
    logic [31:0] d; logic e; int cyc;
    load(1, 8'h5A);
    start_run(1);
    run_send(1, 1'b0, cyc);
    for (int k = 0; k < 6; k++) core_ret(OUT_W'($urandom), (k == 5), (k < OUT_DEPTH));
    apb_read(A_OCNT, d, e);
    checks++; if (d !== 32'(OUT_DEPTH)) begin errors++; $display("FAIL ovf_outcnt: got %0d want %0d", d, OUT_DEPTH); end
    apb_read(A_STAT, d, e);
    checks++; if (d !== 32'h6) begin errors++; $display("FAIL ovf_status: got %h want 6", d); end
    for (int j = 0; j < OUT_DEPTH; j++) begin
      apb_read(A_OUT + 32'(4 * j), d, e);
      checks++; if (d !== 32'(exp_r[0])) begin errors++; $display("FAIL ovf_outbuf%0d: got %h want %h", j, d, exp_r[0]); end
      void'(exp_r.pop_front());
    end
  endtask

  task automatic test_irq_w1c;
    logic [31:0] d; logic e; int cyc;
    apb_write(A_STAT, 32'h6, e);
    irq_en_m = 1'b1;
    apb_write(A_CTRL, 32'h2, e);
    @(posedge HCLK); #1;
    checks++; if (bus.irq_o !== 1'b0) begin errors++; $display("FAIL irq_idle: got %b want 0", bus.irq_o); end
    load(1, 8'h10);
    start_run(1);
    run_send(1, 1'b0, cyc);
    core_ret(9'h033, 1'b1, 1'b1);
    checks++; if (bus.irq_o !== 1'b0) begin errors++; $display("FAIL irq_lag: got %b want 0", bus.irq_o); end
    @(posedge HCLK); #1;
    checks++; if (bus.irq_o !== 1'b1) begin errors++; $display("FAIL irq_set: got %b want 1", bus.irq_o); end
    apb_write(A_STAT, 32'h2, e);
    @(posedge HCLK); #1;
    checks++; if (bus.irq_o !== 1'b0) begin errors++; $display("FAIL irq_clear: got %b want 0", bus.irq_o); end
    apb_read(A_OUT, d, e);
    checks++; if (d !== 32'(exp_r[0])) begin errors++; $display("FAIL irq_outbuf: got %h want %h", d, exp_r[0]); end
    void'(exp_r.pop_front());
    start_run(1);
    run_send(1, 1'b0, cyc);
    fork
      apb_write(A_STAT, 32'h2, e);
      begin @(posedge HCLK); #1 core_ret(9'h144, 1'b1, 1'b1); end
    join
    apb_read(A_STAT, d, e);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL w1c_set_wins: status=%h want 2", d); end
    apb_read(A_OUT, d, e);
    checks++; if (d !== 32'(exp_r[0])) begin errors++; $display("FAIL w1c_outbuf: got %h want %h", d, exp_r[0]); end
    void'(exp_r.pop_front());
  endtask

  task automatic test_aborts;
    logic [31:0] d; logic e; int cyc;
    irq_en_m = 1'b0;
    apb_write(A_CTRL, 32'h0, e);
    apb_write(A_STAT, 32'h6, e);
    load(5, 8'h20);
    start_run(5);
    run_send(2, 1'b0, cyc);
    apb_write(A_CTRL, 32'h4, e);
    exp_s.delete();
    checks++; if ({bus.s_valid_o, bus.m_ready_o} !== 2'b00) begin errors++; $display("FAIL srst_outputs: valid/ready=%b%b want 00", bus.s_valid_o, bus.m_ready_o); end
    apb_read(A_STAT, d, e);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL srst_status: got %h want 0", d); end
    apb_read(A_IN + 32'h8, d, e);
    checks++; if (d !== mem[2]) begin errors++; $display("FAIL srst_inbuf: got %h want %h", d, mem[2]); end
    start_run(5);
    run_send(5, 1'b0, cyc);
    core_ret(9'h0CC, 1'b1, 1'b1);
    apb_read(A_OUT, d, e);
    checks++; if (d !== 32'(exp_r[0])) begin errors++; $display("FAIL resend_outbuf: got %h want %h", d, exp_r[0]); end
    void'(exp_r.pop_front());
    apb_write(A_CTRL, 32'h5, e);
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL start_srst_err: pslverr=%b want 0", e); end
    apb_read(A_STAT, d, e);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL start_srst_status: got %h want 0", d); end
    start_run(1);
    run_send(1, 1'b0, cyc);
    checks++; if (bus.m_ready_o !== 1'b1) begin errors++; $display("FAIL hrst_collect: m_ready=%b want 1", bus.m_ready_o); end
    #2 HRESETn = 1'b0;
    #1;
    checks++; if ({bus.s_valid_o, bus.s_last_o, bus.m_ready_o, bus.irq_o, bus.PSLVERR, bus.PREADY} !== 6'b000001) begin errors++; $display("FAIL hrst_outputs: got %b%b%b%b%b%b want 000001", bus.s_valid_o, bus.s_last_o, bus.m_ready_o, bus.irq_o, bus.PSLVERR, bus.PREADY); end
    checks++; if (bus.PRDATA !== 32'h0) begin errors++; $display("FAIL hrst_prdata: got %h want 0", bus.PRDATA); end
    @(posedge HCLK); #1 HRESETn = 1'b1;
    apb_read(A_LEN, d, e);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL hrst_len: got %h want 0", d); end
    apb_read(A_IN, d, e);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL hrst_inbuf: got %h want 0", d); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_back_to_back();
    test_errors();
    test_overflow();
    test_irq_w1c();
    test_aborts();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
